// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet/IPv4/UDP receive path.
// Contents: wire constants (preamble, SFD, ethertype, IP version/IHL, protocol),
// header lengths, byte offsets counted from the first byte after the SFD,
// the payload-length width and the receive FSM state type.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE_BYTE          = 8'h55;
  localparam logic [7:0]  ETH_SFD_BYTE               = 8'hD5;
  localparam int          ETH_MAC_LENGTH             = 6;
  localparam int          ETH_MAC_HEADER_LENGTH      = 14;
  // Byte-swapped: byte 12 on the wire is [7:0], byte 13 is [15:8].
  localparam logic [15:0] ETH_TYPE_IP                = 16'h0008;
  localparam logic [7:0]  ETH_IP_VER_IHL             = 8'h45;
  localparam logic [7:0]  ETH_IP_PROTO_UDP           = 8'h11;
  localparam int          ETH_IPV4_HEADER_LENGTH     = 20;
  localparam int          ETH_UDP_HEADER_LENGTH      = 8;
  localparam int          ETH_UDP_MAX_PAYLOAD_LENGTH = 1472;

  // Width of a payload length (1..1472).
  localparam int ETH_LEN_W = $clog2(ETH_UDP_MAX_PAYLOAD_LENGTH + 1);

  // Header byte offsets, counted from the first byte after the SFD.
  localparam logic [5:0] ETH_OFS_TYPE     = 6'(2 * ETH_MAC_LENGTH);
  localparam logic [5:0] ETH_OFS_VER_IHL  = 6'(ETH_MAC_HEADER_LENGTH);
  localparam logic [5:0] ETH_OFS_PROTO    = 6'(ETH_MAC_HEADER_LENGTH + 9);
  localparam logic [5:0] ETH_OFS_UDP_DST  = 6'(ETH_MAC_HEADER_LENGTH + ETH_IPV4_HEADER_LENGTH + 2);
  localparam logic [5:0] ETH_OFS_UDP_LEN  = 6'(ETH_MAC_HEADER_LENGTH + ETH_IPV4_HEADER_LENGTH + 4);
  localparam logic [5:0] ETH_OFS_LAST_HDR =
    6'(ETH_MAC_HEADER_LENGTH + ETH_IPV4_HEADER_LENGTH + ETH_UDP_HEADER_LENGTH - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_PREAMBLE,
    RX_HDR,
    RX_PAYLOAD,
    RX_TRAILER
  } rx_state_t;

endpackage

// File: rtl/mac_rx_frame_fifo.sv
// Payload byte FIFO with speculative write / commit / rewind, plus a FIFO of
// committed payload lengths.
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties both FIFOs)
//   wr_en, wr_data    speculative payload byte write at wr_ptr
//   data_full         no room for another byte (checked against the read pointer)
//   commit            publish bytes since the last commit and push their count
//   rewind            discard bytes since the last commit
//   frame_full        length FIFO cannot accept another entry
//   rd_en, rd_data    byte at the read pointer (combinational), advance on rd_en
//   frame_pop         drop the head length
//   frame_empty       no committed frame pending
//   frame_len         head length
module mac_rx_frame_fifo
  import eth_pkg::*;
#(
  parameter int DATA_DEPTH  = 4096,
  parameter int FRAME_DEPTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [7:0]           wr_data,
  output logic                 data_full,
  input  logic                 commit,
  input  logic                 rewind,
  output logic                 frame_full,
  input  logic                 rd_en,
  output logic [7:0]           rd_data,
  input  logic                 frame_pop,
  output logic                 frame_empty,
  output logic [ETH_LEN_W-1:0] frame_len
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int FW = $clog2(FRAME_DEPTH);

  logic [7:0]           data_mem [DATA_DEPTH];
  logic [ETH_LEN_W-1:0] len_mem  [FRAME_DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] committed_ptr_q, committed_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [FW:0] frame_wr_q, frame_wr_d;
  logic [FW:0] frame_rd_q, frame_rd_d;

  logic [ETH_LEN_W-1:0] commit_len;
  logic                 wr_ok;

  assign data_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign frame_full  = (frame_wr_q[FW] != frame_rd_q[FW]) &&
                       (frame_wr_q[FW-1:0] == frame_rd_q[FW-1:0]);
  assign frame_empty = (frame_wr_q == frame_rd_q);
  assign rd_data     = data_mem[rd_ptr_q[AW-1:0]];
  assign frame_len   = len_mem[frame_rd_q[FW-1:0]];
  assign commit_len  = ETH_LEN_W'(wr_ptr_q - committed_ptr_q);
  assign wr_ok       = wr_en && !data_full;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    wr_ptr_d        = wr_ptr_q;
    committed_ptr_d = committed_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    frame_wr_d      = frame_wr_q;
    frame_rd_d      = frame_rd_q;
    if (rewind) begin
      wr_ptr_d = committed_ptr_q;
    end else if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (commit) begin
      committed_ptr_d = wr_ptr_q;
      frame_wr_d      = frame_wr_q + 1'b1;
    end
    if (rd_en)     rd_ptr_d   = rd_ptr_q + 1'b1;
    if (frame_pop) frame_rd_d = frame_rd_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      committed_ptr_q <= '0;
      rd_ptr_q        <= '0;
      frame_wr_q      <= '0;
      frame_rd_q      <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      committed_ptr_q <= committed_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      frame_wr_q      <= frame_wr_d;
      frame_rd_q      <= frame_rd_d;
    end
  end

  // NOTE: storage arrays are not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_ok)  data_mem[wr_ptr_q[AW-1:0]]  <= wr_data;
    if (commit) len_mem[frame_wr_q[FW-1:0]] <= commit_len;
  end

endmodule

// File: rtl/mac_rx_to_udp.sv
// Receive-side Ethernet/IPv4/UDP parser. Strips preamble/SFD and the MAC, IPv4
// and UDP headers, buffers the payload of good frames addressed to
// Udp_filter_port and replays each one as an AXI-Stream byte packet.
// Ports:
//   Clk, Rst                          clock, synchronous active-high reset
//   Udp_filter_port                   UDP destination port to accept
//   Mac_valid, Mac_data, Mac_error    GMII-style byte stream (frame = run of Mac_valid)
//   Mac_accepted                      1 if the most recently ended frame was committed
//   Udp_data, Udp_valid, Udp_last     AXI-Stream payload output
//   Udp_ready                         AXI-Stream back-pressure
module mac_rx_to_udp
  import eth_pkg::*;
#(
  parameter int INPUT_BUFFER_DATA_DEPTH  = 4096,
  parameter int INPUT_BUFFER_FRAME_DEPTH = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] Udp_filter_port,
  input  logic        Mac_valid,
  input  logic [7:0]  Mac_data,
  input  logic        Mac_error,
  output logic        Mac_accepted,
  output logic [7:0]  Udp_data,
  output logic        Udp_valid,
  output logic        Udp_last,
  input  logic        Udp_ready
);

  // Receive side state.
  rx_state_t            state_q, state_d;
  logic [5:0]           hdr_cnt_q, hdr_cnt_d;
  logic [ETH_LEN_W-1:0] pay_cnt_q, pay_cnt_d;
  logic [ETH_LEN_W-1:0] pay_len_q, pay_len_d;
  logic [7:0]           len_hi_q, len_hi_d;
  logic                 sfd_seen_q, sfd_seen_d;
  logic                 bad_q, bad_d;
  logic                 done_q, done_d;
  logic                 accepted_q, accepted_d;
  logic                 hdr_ok, frame_good;
  logic [15:0]          udp_len;

  // Transmit side state.
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 tx_last_q, tx_last_d;
  logic                 tx_active_q, tx_active_d;
  logic [ETH_LEN_W-1:0] tx_left_q, tx_left_d;
  logic                 load_ok;

  // FIFO interface.
  logic                 wr_en, commit, rewind, rd_en, frame_pop;
  logic                 data_full, frame_full, frame_empty;
  logic [7:0]           rd_data;
  logic [ETH_LEN_W-1:0] frame_len;

  assign udp_len = {len_hi_q, Mac_data};

  mac_rx_frame_fifo #(
    .DATA_DEPTH (INPUT_BUFFER_DATA_DEPTH),
    .FRAME_DEPTH(INPUT_BUFFER_FRAME_DEPTH)
  ) u_fifo (
    .clk        (Clk),
    .rst        (Rst),
    .wr_en      (wr_en),
    .wr_data    (Mac_data),
    .data_full  (data_full),
    .commit     (commit),
    .rewind     (rewind),
    .frame_full (frame_full),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .frame_pop  (frame_pop),
    .frame_empty(frame_empty),
    .frame_len  (frame_len)
  );

  // ---------------- Receive parser ----------------
  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    pay_cnt_d  = pay_cnt_q;
    pay_len_d  = pay_len_q;
    len_hi_d   = len_hi_q;
    sfd_seen_d = sfd_seen_q;
    bad_d      = bad_q;
    done_d     = done_q;
    accepted_d = accepted_q;
    hdr_ok     = 1'b1;
    frame_good = 1'b0;
    wr_en      = 1'b0;
    commit     = 1'b0;
    rewind     = 1'b0;

    if (state_q != RX_IDLE && !Mac_valid) begin
      // Frame end. Bursts that never showed an SFD leave the status alone.
      state_d = RX_IDLE;
      if (sfd_seen_q) begin
        frame_good = !bad_q && done_q && !frame_full;
        accepted_d = frame_good;
        commit     = frame_good;
        rewind     = !frame_good;
      end
    end else if (Mac_valid) begin
      case (state_q)
        RX_IDLE: begin
          bad_d      = Mac_error;
          done_d     = 1'b0;
          hdr_cnt_d  = '0;
          pay_cnt_d  = '0;
          sfd_seen_d = (Mac_data == ETH_SFD_BYTE);
          if (Mac_data == ETH_SFD_BYTE)           state_d = RX_HDR;
          else if (Mac_data == ETH_PREAMBLE_BYTE) state_d = RX_PREAMBLE;
          else                                    state_d = RX_TRAILER;
        end
        RX_PREAMBLE: begin
          bad_d = bad_q || Mac_error;
          if (Mac_data == ETH_SFD_BYTE) begin
            sfd_seen_d = 1'b1;
            state_d    = RX_HDR;
          end else if (Mac_data != ETH_PREAMBLE_BYTE) begin
            state_d = RX_TRAILER;
          end
        end
        RX_HDR: begin
          hdr_cnt_d = hdr_cnt_q + 1'b1;
          case (hdr_cnt_q)
            ETH_OFS_TYPE:            hdr_ok = (Mac_data == ETH_TYPE_IP[7:0]);
            ETH_OFS_TYPE + 6'd1:     hdr_ok = (Mac_data == ETH_TYPE_IP[15:8]);
            ETH_OFS_VER_IHL:         hdr_ok = (Mac_data == ETH_IP_VER_IHL);
            ETH_OFS_PROTO:           hdr_ok = (Mac_data == ETH_IP_PROTO_UDP);
            ETH_OFS_UDP_DST:         hdr_ok = (Mac_data == Udp_filter_port[15:8]);
            ETH_OFS_UDP_DST + 6'd1:  hdr_ok = (Mac_data == Udp_filter_port[7:0]);
            ETH_OFS_UDP_LEN:         len_hi_d = Mac_data;
            ETH_OFS_UDP_LEN + 6'd1: begin
              hdr_ok = (udp_len > 16'(ETH_UDP_HEADER_LENGTH)) &&
                       (udp_len <= 16'(ETH_UDP_HEADER_LENGTH + ETH_UDP_MAX_PAYLOAD_LENGTH));
              pay_len_d = ETH_LEN_W'(udp_len - 16'(ETH_UDP_HEADER_LENGTH));
            end
            default: ;
          endcase
          bad_d = bad_q || Mac_error || !hdr_ok;
          if (bad_d)                               state_d = RX_TRAILER;
          else if (hdr_cnt_q == ETH_OFS_LAST_HDR)  state_d = RX_PAYLOAD;
        end
        RX_PAYLOAD: begin
          if (data_full) begin
            bad_d   = 1'b1;
            state_d = RX_TRAILER;
          end else begin
            wr_en     = 1'b1;
            bad_d     = bad_q || Mac_error;
            pay_cnt_d = pay_cnt_q + 1'b1;
            if (pay_cnt_q == pay_len_q - 1'b1) begin
              done_d  = 1'b1;
              state_d = RX_TRAILER;
            end
          end
        end
        RX_TRAILER: bad_d = bad_q || Mac_error;
        default:    state_d = RX_IDLE;
      endcase
    end
  end

  // ---------------- AXI-S output stage ----------------
  // The head length stays in the frame FIFO until its last byte is taken, so a
  // stalled packet still occupies a frame slot.
  always_comb begin
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    tx_last_d   = tx_last_q;
    tx_active_d = tx_active_q;
    tx_left_d   = tx_left_q;
    rd_en       = 1'b0;
    load_ok     = !tx_valid_q || Udp_ready;
    frame_pop   = tx_valid_q && Udp_ready && tx_last_q;

    if (frame_pop) tx_active_d = 1'b0;
    if (load_ok) begin
      if (tx_left_q != '0) begin
        rd_en      = 1'b1;
        tx_data_d  = rd_data;
        tx_valid_d = 1'b1;
        tx_last_d  = (tx_left_q == ETH_LEN_W'(1));
        tx_left_d  = tx_left_q - 1'b1;
      end else if (!tx_active_q && !frame_empty) begin
        rd_en       = 1'b1;
        tx_data_d   = rd_data;
        tx_valid_d  = 1'b1;
        tx_last_d   = (frame_len == ETH_LEN_W'(1));
        tx_left_d   = frame_len - 1'b1;
        tx_active_d = 1'b1;
      end else begin
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= RX_IDLE;
      hdr_cnt_q   <= '0;
      pay_cnt_q   <= '0;
      pay_len_q   <= '0;
      len_hi_q    <= '0;
      sfd_seen_q  <= 1'b0;
      bad_q       <= 1'b0;
      done_q      <= 1'b0;
      accepted_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      tx_active_q <= 1'b0;
      tx_left_q   <= '0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      pay_len_q   <= pay_len_d;
      len_hi_q    <= len_hi_d;
      sfd_seen_q  <= sfd_seen_d;
      bad_q       <= bad_d;
      done_q      <= done_d;
      accepted_q  <= accepted_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_last_q   <= tx_last_d;
      tx_active_q <= tx_active_d;
      tx_left_q   <= tx_left_d;
    end
  end

  assign Mac_accepted = accepted_q;
  assign Udp_data     = tx_data_q;
  assign Udp_valid    = tx_valid_q;
  assign Udp_last     = tx_last_q;

endmodule

// File: tb/tb_mac_rx_to_udp.sv
// Self-checking bench for mac_rx_to_udp: frames are built in the bench, the
// expected payload bytes ({last, data}) are queued when a frame that should be
// accepted is sent, and popped as the DUT hands bytes over.
module tb_mac_rx_to_udp;

  localparam logic [15:0] FILTER = 16'h1234;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] Udp_filter_port = FILTER;
  logic        Mac_valid = 1'b0;
  logic [7:0]  Mac_data = 8'h00;
  logic        Mac_error = 1'b0;
  logic        Mac_accepted;
  logic [7:0]  Udp_data;
  logic        Udp_valid;
  logic        Udp_last;
  logic        Udp_ready = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;
  int          ready_mode = 1;  // 0: never ready, 1: always ready, 2: random 80%
  logic [8:0]  exp_q[$];
  logic [7:0]  fb[$];
  logic [7:0]  pay[$];
  logic        prev_hold = 1'b0;
  logic [8:0]  prev_out = '0;

  mac_rx_to_udp dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Udp_filter_port(Udp_filter_port),
    .Mac_valid      (Mac_valid),
    .Mac_data       (Mac_data),
    .Mac_error      (Mac_error),
    .Mac_accepted   (Mac_accepted),
    .Udp_data       (Udp_data),
    .Udp_valid      (Udp_valid),
    .Udp_last       (Udp_last),
    .Udp_ready      (Udp_ready)
  );

  always #5 Clk = ~Clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge Clk) begin
    #1;
    case (ready_mode)
      0:       Udp_ready = 1'b0;
      1:       Udp_ready = 1'b1;
      default: Udp_ready = ($urandom_range(0, 99) < 80);
    endcase
  end

  // Output monitor: sampled mid-cycle; a transfer happens on the next rising edge.
  always @(negedge Clk) begin
    logic [8:0] e;
    if (!Rst && prev_hold) begin
      check("hold_valid", Udp_valid, 1);
      check("hold_byte", {Udp_last, Udp_data}, prev_out);
    end
    prev_hold = !Rst && Udp_valid && !Udp_ready;
    prev_out  = {Udp_last, Udp_data};
    if (!Rst && Udp_valid && Udp_ready) begin
      check("exp_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("udp_byte", {Udp_last, Udp_data}, e);
      end
    end
  end

  task automatic build_frame(input logic [15:0] dport, input logic [15:0] udp_len, input int plen,
                             input int pad, input logic [15:0] etype, input logic [7:0] ver,
                             input logic [7:0] proto);
    logic [7:0] b;
    fb.delete();
    pay.delete();
    repeat (3) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    for (int i = 0; i < 12; i++) fb.push_back(8'(i + 1));
    fb.push_back(etype[15:8]);
    fb.push_back(etype[7:0]);
    fb.push_back(ver);
    for (int i = 0; i < 8; i++) fb.push_back(8'(i + 'hA0));
    fb.push_back(proto);
    for (int i = 0; i < 10; i++) fb.push_back(8'(i + 'hC0));
    fb.push_back(8'hAB);
    fb.push_back(8'hCD);
    fb.push_back(dport[15:8]);
    fb.push_back(dport[7:0]);
    fb.push_back(udp_len[15:8]);
    fb.push_back(udp_len[7:0]);
    fb.push_back(8'h00);
    fb.push_back(8'h00);
    for (int i = 0; i < plen; i++) begin
      b = 8'($urandom);
      pay.push_back(b);
      fb.push_back(b);
    end
    for (int i = 0; i < pad; i++) fb.push_back(8'h00);
    for (int i = 0; i < 4; i++) fb.push_back(8'($urandom));
  endtask

  task automatic good_frame(input int plen);
    build_frame(FILTER, 16'(plen + 8), plen, 0, 16'h0800, 8'h45, 8'h11);
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic e);
    @(posedge Clk);
    #1;
    Mac_valid = 1'b1;
    Mac_data  = d;
    Mac_error = e;
  endtask

  task automatic end_frame();
    @(posedge Clk);
    #1;
    Mac_valid = 1'b0;
    Mac_data  = 8'h00;
    Mac_error = 1'b0;
  endtask

  task automatic send_frame(input logic exp_ok, input int err_idx, input string tag);
    logic lst;
    if (exp_ok) begin
      for (int i = 0; i < pay.size(); i++) begin
        lst = (i == pay.size() - 1);
        exp_q.push_back({lst, pay[i]});
      end
    end
    for (int i = 0; i < fb.size(); i++) drive_byte(fb[i], i == err_idx);
    end_frame();
    repeat (2) @(posedge Clk);
    #1;
    check(tag, Mac_accepted, exp_ok);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 6000 && exp_q.size() != 0; i++) @(posedge Clk);
    repeat (4) @(posedge Clk);
    check("drain_empty", exp_q.size(), 0);
    @(negedge Clk);
    check("idle_valid", Udp_valid, 0);
  endtask

  initial begin
    int kind, plen, idx;

    // Reset state.
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    check("rst_accepted", Mac_accepted, 0);
    check("rst_valid", Udp_valid, 0);
    check("rst_last", Udp_last, 0);

    // Reference good frame with fixed payload A1 B2 C3 D4.
    good_frame(4);
    pay.delete();
    pay.push_back(8'hA1);
    pay.push_back(8'hB2);
    pay.push_back(8'hC3);
    pay.push_back(8'hD4);
    for (int i = 0; i < 4; i++) fb[46 + i] = pay[i];
    send_frame(1'b1, -1, "acc_good");

    // A burst with no SFD leaves the status unchanged.
    drive_byte(8'h12, 1'b0);
    drive_byte(8'h34, 1'b0);
    end_frame();
    repeat (2) @(posedge Clk);
    #1 check("acc_nonframe", Mac_accepted, 1);

    // Header rejects.
    build_frame(FILTER ^ 16'h0001, 16'd12, 4, 0, 16'h0800, 8'h45, 8'h11);
    send_frame(1'b0, -1, "acc_bad_port");
    build_frame(FILTER, 16'd12, 4, 0, 16'h0900, 8'h45, 8'h11);
    send_frame(1'b0, -1, "acc_bad_etype");
    build_frame(FILTER, 16'd12, 4, 0, 16'h0800, 8'h46, 8'h11);
    send_frame(1'b0, -1, "acc_bad_ver");
    build_frame(FILTER, 16'd12, 4, 0, 16'h0800, 8'h45, 8'h06);
    send_frame(1'b0, -1, "acc_bad_proto");

    // Length boundaries.
    build_frame(FILTER, 16'd8, 0, 4, 16'h0800, 8'h45, 8'h11);
    send_frame(1'b0, -1, "acc_len8");
    build_frame(FILTER, 16'd1481, 4, 0, 16'h0800, 8'h45, 8'h11);
    send_frame(1'b0, -1, "acc_len1481");
    build_frame(FILTER, 16'd1480, 1472, 8, 16'h0800, 8'h45, 8'h11);
    send_frame(1'b1, -1, "acc_len1480");

    // Frame ends one byte before the last payload byte.
    good_frame(10);
    while (fb.size() > 4 + 42 + 9) void'(fb.pop_back());
    send_frame(1'b0, -1, "acc_truncated");

    // Byte errors in preamble, payload and FCS, then an intact frame.
    good_frame(6);
    send_frame(1'b0, 1, "acc_err_pre");
    good_frame(6);
    send_frame(1'b0, 4 + 42 + 2, "acc_err_pay");
    good_frame(6);
    send_frame(1'b0, fb.size() - 1, "acc_err_fcs");
    good_frame(7);
    send_frame(1'b1, -1, "acc_after_err");
    wait_drain();

    // Random traffic with random back-pressure.
    ready_mode = 2;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      plen = $urandom_range(1, 64);
      if (kind < 7) begin
        good_frame(plen);
        send_frame(1'b1, -1, "acc_rand_good");
      end else if (kind == 7) begin
        build_frame(FILTER + 16'd1, 16'(plen + 8), plen, 0, 16'h0800, 8'h45, 8'h11);
        send_frame(1'b0, -1, "acc_rand_port");
      end else if (kind == 8) begin
        good_frame(plen);
        idx = $urandom_range(0, fb.size() - 1);
        send_frame(1'b0, idx, "acc_rand_err");
      end else begin
        build_frame(FILTER, 16'(plen + 8), plen, 0, 16'h0800, 8'h45, 8'h06);
        send_frame(1'b0, -1, "acc_rand_proto");
      end
    end
    ready_mode = 1;
    wait_drain();

    // Frame FIFO capacity: 64 frames held, the 65th dropped.
    ready_mode = 0;
    repeat (2) @(posedge Clk);
    for (int n = 0; n < 65; n++) begin
      good_frame(4);
      send_frame(n < 64, -1, (n < 64) ? "acc_fill" : "acc_frame_full");
    end
    ready_mode = 1;
    wait_drain();

    // Reset in the middle of an output packet.
    ready_mode = 0;
    repeat (2) @(posedge Clk);
    good_frame(8);
    send_frame(1'b1, -1, "acc_pre_rst");
    for (int i = 0; i < 20 && !Udp_valid; i++) @(posedge Clk);
    @(negedge Clk);
    check("valid_before_rst", Udp_valid, 1);
    @(posedge Clk);
    #1 Rst = 1'b1;
    @(posedge Clk);
    #1 Rst = 1'b0;
    exp_q.delete();
    @(negedge Clk);
    check("post_rst_valid", Udp_valid, 0);
    check("post_rst_last", Udp_last, 0);
    check("post_rst_accepted", Mac_accepted, 0);
    ready_mode = 1;
    good_frame(5);
    send_frame(1'b1, -1, "acc_post_rst");
    for (int n = 0; n < 3; n++) begin
      good_frame($urandom_range(1, 32));
      send_frame(1'b1, -1, "acc_post_rst_more");
    end
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
